// File: rtl/wb_block_reader_if.sv
// Wishbone read-master bus bundle used by wb_block_reader.
// The master modport is the reader side; the slave modport is the memory side.
interface wb_block_reader_if;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [31:0] wb_dat_ms;
    logic [31:0] wb_dat_sm;
    logic        wb_ack;
    logic        wb_err;
    logic        wb_rty;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_cti, wb_bte, wb_dat_ms,
        input  wb_dat_sm, wb_ack, wb_err, wb_rty
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_cti, wb_bte, wb_dat_ms,
        output wb_dat_sm, wb_ack, wb_err, wb_rty
    );
endinterface

// File: rtl/wb_block_reader.sv
// Wishbone block reader: fetches nb_words consecutive words into a FIFO and streams them out.
// Define WB_BURST_EN for registered incrementing bursts (one word per cycle).
module wb_block_reader #(
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          base_adr,
    input  logic [LEN_WIDTH-1:0] nb_words,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    wb_block_reader_if.master    wb,
    output logic [31:0]          out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);
`ifdef WB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = AW + 2;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

    state_t               state_r;
    logic [31:0]          adr_r;
    logic [LEN_WIDTH-1:0] rem_r;
    logic                 cyc_r, stb_r, busy_r, done_r, error_r;
    logic [2:0]           cti_r;
    logic [31:0]          mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]        cnt_r;
    logic                 push_s, pop_s;
    logic [FW-1:0]        fill_s;
    logic                 full_after_s, full_after2_s, free2_s;

    // Cycle type for a beat about to be issued; "last" closes the burst.
    function automatic logic [2:0] next_cti(input logic last);
        if (!BURST) next_cti = 3'b000;
        else if (last) next_cti = 3'b111;
        else next_cti = 3'b010;
    endfunction

    // Fill projections are conservative: pops only ever add room.
    always_comb begin
        fill_s        = FW'(cnt_r);
        full_after_s  = (fill_s + FW'(2'd1)) >= FW'(FIFO_DEPTH);
        full_after2_s = (fill_s + FW'(2'd2)) >= FW'(FIFO_DEPTH);
        free2_s       = (fill_s + FW'(2'd2)) <= FW'(FIFO_DEPTH);
    end

    // FIFO push on an acknowledged beat, pop on a stream handshake.
    always_comb begin
        push_s = 1'b0;
        if (!rst && state_r == ST_REQ && stb_r && wb.wb_ack) push_s = 1'b1;
        else push_s = 1'b0;
        pop_s = (cnt_r != {CW{1'b0}}) && out_ready;
    end

    // Control FSM: sequences Wishbone beats and raises the status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            adr_r   <= 32'd0;
            rem_r   <= {LEN_WIDTH{1'b0}};
            cyc_r   <= 1'b0;
            stb_r   <= 1'b0;
            cti_r   <= 3'b000;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        adr_r   <= base_adr & 32'hFFFF_FFFC;
                        rem_r   <= nb_words;
                        error_r <= 1'b0;
                        if (nb_words == {LEN_WIDTH{1'b0}}) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else if (!free2_s) begin
                            state_r <= ST_WAIT;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= ST_REQ;
                            busy_r  <= 1'b1;
                            cyc_r   <= 1'b1;
                            stb_r   <= 1'b1;
                            cti_r   <= next_cti(nb_words == LEN_WIDTH'(1'b1));
                        end
                    end
                end
                ST_REQ: begin
                    if (!stb_r) begin
                        // Gap after a classic ack or a retry: re-issue at the current address.
                        cyc_r <= 1'b1;
                        stb_r <= 1'b1;
                        cti_r <= next_cti(rem_r == LEN_WIDTH'(1'b1) || full_after_s);
                    end else if (wb.wb_ack) begin
                        adr_r <= adr_r + 32'd4;
                        rem_r <= rem_r - LEN_WIDTH'(1'b1);
                        if (rem_r == LEN_WIDTH'(1'b1)) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            cyc_r   <= 1'b0;
                            stb_r   <= 1'b0;
                            cti_r   <= 3'b000;
                        end else if (BURST ? (cti_r == 3'b111) : full_after_s) begin
                            state_r <= ST_WAIT;
                            cyc_r   <= 1'b0;
                            stb_r   <= 1'b0;
                            cti_r   <= 3'b000;
                        end else if (BURST) begin
                            cti_r <= next_cti(rem_r == LEN_WIDTH'(2'd2) || full_after2_s);
                        end else begin
                            stb_r <= 1'b0;
                        end
                    end else if (wb.wb_err) begin
                        error_r <= 1'b1;
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        cyc_r   <= 1'b0;
                        stb_r   <= 1'b0;
                        cti_r   <= 3'b000;
                    end else if (wb.wb_rty) begin
                        // A burst is abandoned on retry; classic keeps the cycle open.
                        cyc_r <= !BURST;
                        stb_r <= 1'b0;
                        cti_r <= 3'b000;
                    end else begin
                        stb_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (free2_s) begin
                        state_r <= ST_REQ;
                        cyc_r   <= 1'b1;
                        stb_r   <= 1'b1;
                        cti_r   <= next_cti(rem_r == LEN_WIDTH'(1'b1) || full_after_s);
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cyc_r   <= 1'b0;
                    stb_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1'b1);
                2'b01:   cnt_r <= cnt_r - CW'(1'b1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= wb.wb_dat_sm;
    end

    assign out_data     = mem_r[rd_ptr_r];
    assign out_valid    = (cnt_r != {CW{1'b0}});
    assign busy         = busy_r;
    assign done         = done_r;
    assign error        = error_r;
    assign wb.wb_cyc    = cyc_r;
    assign wb.wb_stb    = stb_r;
    assign wb.wb_we     = 1'b0;
    assign wb.wb_adr    = adr_r;
    assign wb.wb_sel    = 4'hF;
    assign wb.wb_cti    = cti_r;
    assign wb.wb_bte    = 2'b00;
    assign wb.wb_dat_ms = 32'd0;
endmodule

// File: doc/wb_block_reader.md
Name: wb_block_reader

Overview:
- Wishbone read-only master. Fetches a block of consecutive 32-bit words from a Wishbone slave (e.g. the team's BlockRAM) and delivers them in address order on a valid/ready output stream.
- Decouples the two sides with an internal FIFO.
- Sits between the memory controller's slave port and a streaming consumer, such as a display or DMA sink.

Parameters:
- FIFO_DEPTH, 16, output FIFO depth in words; power of two, ≥ 2.
- LEN_WIDTH, 16, width of the word-count input; maximum block size is 2**LEN_WIDTH - 1 words.

Ports:
- clk  input  1  system clock, same as the Wishbone interface clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse that launches a block read; sampled only in IDLE.
- base_adr  input  32  byte address of the first word; bits [1:0] are ignored and forced to 0.
- nb_words  input  LEN_WIDTH  number of words to read; 0 means no Wishbone activity.
- busy  output  1  high from the cycle after an accepted start until the transfer ends.
- done  output  1  one-cycle pulse when the last word has been pushed into the FIFO.
- error  output  1  sticky error flag; set by err, cleared by the next accepted start or by rst.
- wb_cyc  output  1  Wishbone cycle.
- wb_stb  output  1  Wishbone strobe.
- wb_we  output  1  Wishbone write enable; always 0.
- wb_adr  output  32  Wishbone byte address.
- wb_sel  output  4  Wishbone byte select; always 4'hF.
- wb_cti  output  3  Wishbone cycle type identifier.
- wb_bte  output  2  Wishbone burst type; always 2'b00.
- wb_dat_ms  output  32  Wishbone write data; always 0.
- wb_dat_sm  input  32  Wishbone read data.
- wb_ack  input  1  Wishbone acknowledge.
- wb_err  input  1  Wishbone error.
- wb_rty  input  1  Wishbone retry.
- out_data  output  32  head word of the FIFO.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE and the FIFO is flushed.
  - All of the following are 0: cyc, stb, busy, done, error, out_valid, wb_adr, wb_cti, and the counters.
  - rst in the middle of a transfer takes effect at that edge: cyc and stb drop the next cycle, and no further words are pushed.
- State machine:
  - IDLE → REQ on start with nb_words ≠ 0. Captures the address, clears error, sets busy.
  - IDLE → DONE on start with nb_words = 0. done pulses with no bus cycle.
  - REQ drives cyc=stb=1 and holds wb_adr stable until the slave responds.
  - REQ on ack: push wb_dat_sm into the FIFO, adr += 4, decrement the remaining count.
    - Remaining count reaches 0 → DONE.
    - FIFO has no room for one more word (count + 1 ≥ FIFO_DEPTH after the push) → WAIT, with cyc=stb=0.
    - Otherwise stay in REQ and issue the next address in the following cycle.
  - REQ on rty (no ack): drop stb for one cycle, then re-issue the same address. No push, no count change.
  - REQ on err: set error, drop cyc and stb, → DONE. Words already fetched remain in the FIFO.
  - WAIT → REQ when the FIFO has at least 2 free entries.
  - DONE: done=1 for one cycle, busy=0, → IDLE.
- Simultaneous responses: ack has priority over err, and err over rty.
- Handshake rules: start while busy is ignored. stb is never asserted without cyc.
- Address arithmetic: 32-bit, wraps modulo 2**32 without any flag.
- Throughput (classic mode): one word every 2 cycles with a zero-wait-state slave. stb is deasserted for one cycle after each ack.
- FIFO:
  - A push and a pop in the same cycle are both allowed; when the FIFO is full, the pop frees the entry in that same cycle.
  - out_data is stable while out_valid && !out_ready.
  - Data order always equals address order.

Optional Feature:
- Macro: WB_BURST_EN.
- When defined:
  - Uses a registered incrementing burst: wb_cti=3'b010 and wb_bte=2'b00.
  - stb stays high across consecutive acks, giving one word per cycle.
  - The beat for the last word of the block, and the beat before any entry into WAIT, carry wb_cti=3'b111.
  - After rty or err the burst ends: the next beat restarts as a new cycle.
- When not defined: wb_cti is constantly 3'b000 (classic cycles) with the 2-cycle throughput above.

Test Plan:
- Basic read:
  - Stimulus: preload the slave with mem[i]=i; base 0x100, nb_words=8, out_ready=1.
  - Response: out stream 0x40..0x47 in order; addresses 0x100..0x11C; single done pulse; error=0.
- Back-pressure:
  - Stimulus: FIFO_DEPTH=4, nb_words=20, out_ready held 0 for 50 cycles, then 1.
  - Response: cyc drops when the FIFO fills; no overflow; all 20 words arrive exactly once and in order.
- Error:
  - Stimulus: slave asserts err on the 3rd word.
  - Response: error=1, done pulses, only 2 words delivered, cyc=0 on the next cycle; the next start clears error.
- Retry and zero length:
  - Stimulus: rty on the 1st access, then ack; separately, nb_words=0.
  - Response: the same address is re-issued and the data is correct; zero length gives done one cycle after start with cyc never asserted.
- Reset mid-transfer:
  - Stimulus: rst for one cycle in the middle of a 16-word read.
  - Response: cyc, stb, busy and out_valid are 0 the next cycle; a new start afterwards completes correctly.
- Burst mode (WB_BURST_EN):
  - Stimulus: 8-word read, zero-wait-state slave.
  - Response: 8 acks in 8 consecutive cycles; wb_cti is 010 on beats 1-7 and 111 on beat 8.
